// File: rtl/kb_mem_writer.sv
// PS/2 keyboard receiver and scan-code decoder that posts each make code into
// a single memory key slot, waiting until the CPU has consumed the previous key.
module kb_mem_writer #(
    parameter logic [31:0] KEY_ADDR       = 32'h0000_00F0,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [31:0] code_key,
    output logic        we_kb,
    output logic [31:0] addr_kb,
    output logic [31:0] data_kb,
    output logic        frame_err,
    output logic        pending_valid
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t        state, state_nxt;
    logic          clk_meta, clk_sync, clk_prev;
    logic          data_meta, data_sync;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic [TW-1:0] tmo_cnt;
    logic          timeout;
    logic          frame_ok;
    logic          byte_vld;
    logic [7:0]    rx_byte;
    logic          ext, brk;
    logic [31:0]   pending;
    logic [31:0]   data_last;
    logic          we_prev;

    // Synchronizers idle high, matching an idle PS/2 bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fall     = clk_prev & ~clk_sync;
    assign timeout  = (tmo_cnt == TW'(TIMEOUT_CYCLES));
    assign frame_ok = (^shift[8:0]) & shift[9];
    assign rx_byte  = shift[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall && !data_sync) state_nxt = RECV;
            RECV:    if (timeout) state_nxt = IDLE;
                     else if (fall && bit_cnt == 4'd9) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_vld  = 1'b0;
        frame_err = 1'b0;
        case (state)
            RECV:    frame_err = timeout;
            CHECK: begin
                byte_vld  = frame_ok;
                frame_err = ~frame_ok;
            end
            default: ;
        endcase
    end

    // Frame bits land at their position: 0-7 data, 8 parity, 9 stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else if (state == RECV) begin
            if (fall) begin
                shift[bit_cnt] <= data_sync;
                bit_cnt        <= bit_cnt + 4'd1;
                tmo_cnt        <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    // A load in the same cycle as a write wins over the write's clear of pending_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext           <= 1'b0;
            brk           <= 1'b0;
            pending       <= '0;
            pending_valid <= 1'b0;
            data_last     <= '0;
            we_prev       <= 1'b0;
        end else begin
            we_prev <= we_kb;
            if (we_kb) begin
                data_last     <= pending;
                pending_valid <= 1'b0;
            end
            if (byte_vld) begin
                case (rx_byte)
                    8'hE0: ext <= 1'b1;
                    8'hF0: brk <= 1'b1;
                    8'h00: ;
                    default: begin
                        if (!brk) begin
                            pending       <= {16'h0000, (ext ? 8'hE0 : 8'h00), rx_byte};
                            pending_valid <= 1'b1;
                        end
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign we_kb   = pending_valid & (code_key == 32'h0) & ~we_prev;
    assign data_kb = we_kb ? pending : data_last;
    assign addr_kb = KEY_ADDR;

endmodule

// File: tb/tb_kb_mem_writer.sv
// Directed bench for kb_mem_writer: bit-banged PS/2 frames, table of single
// transactions plus hand sequences for back-pressure, timeout and reset.
module tb_kb_mem_writer;
    localparam int TMO = 300;
    localparam int H   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] code_key;
    logic        we_kb;
    logic [31:0] addr_kb;
    logic [31:0] data_kb;
    logic        frame_err;
    logic        pending_valid;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int err_cnt = 0;
    int viol = 0;
    logic [31:0] last_data = 32'h0;
    logic we_seen_prev = 1'b0;

    kb_mem_writer #(.KEY_ADDR(32'h0000_00F0), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code_key(code_key), .we_kb(we_kb), .addr_kb(addr_kb), .data_kb(data_kb),
        .frame_err(frame_err), .pending_valid(pending_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (we_kb) begin
                we_cnt    = we_cnt + 1;
                last_data = data_kb;
                if (code_key != 32'h0) viol = viol + 1;
                if (we_seen_prev) viol = viol + 1;
            end
            if (frame_err) err_cnt = err_cnt + 1;
            we_seen_prev = we_kb;
        end else begin
            we_seen_prev = 1'b0;
        end
    end

    typedef struct {
        int          n;
        logic [7:0]  b0, b1, b2;
        logic        bad;
        int          writes;
        logic [31:0] data;
        int          errs;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (H) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * H) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        send_bits(b, bad, 11);
    endtask

    int w0, e0;
    logic [31:0] exp_last;

    initial begin
        vecs[0] = '{1, 8'h1C, 8'h00, 8'h00, 1'b0, 1, 32'h0000001C, 0};
        vecs[1] = '{2, 8'hF0, 8'h1C, 8'h00, 1'b0, 0, 32'h0, 0};
        vecs[2] = '{2, 8'hE0, 8'h75, 8'h00, 1'b0, 1, 32'h0000E075, 0};
        vecs[3] = '{1, 8'h1C, 8'h00, 8'h00, 1'b1, 0, 32'h0, 1};
        vecs[4] = '{1, 8'h32, 8'h00, 8'h00, 1'b0, 1, 32'h00000032, 0};
        vecs[5] = '{3, 8'hE0, 8'hF0, 8'h75, 1'b0, 0, 32'h0, 0};
        vecs[6] = '{1, 8'h75, 8'h00, 8'h00, 1'b0, 1, 32'h00000075, 0};
        vecs[7] = '{3, 8'hE0, 8'h00, 8'h74, 1'b0, 1, 32'h0000E074, 0};

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; code_key = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", {31'h0, we_kb}, 32'h0);
        check("rst_err", {31'h0, frame_err}, 32'h0);
        check("rst_pend", {31'h0, pending_valid}, 32'h0);
        check("rst_addr", addr_kb, 32'h000000F0);
        check("rst_data", data_kb, 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        exp_last = 32'h0;
        for (int v = 0; v < 8; v++) begin
            w0 = we_cnt; e0 = err_cnt;
            send_byte(vecs[v].b0, (vecs[v].n == 1) ? vecs[v].bad : 1'b0);
            if (vecs[v].n > 1) send_byte(vecs[v].b1, (vecs[v].n == 2) ? vecs[v].bad : 1'b0);
            if (vecs[v].n > 2) send_byte(vecs[v].b2, vecs[v].bad);
            repeat (10) @(posedge clk);
            @(negedge clk);
            if (vecs[v].writes > 0) exp_last = vecs[v].data;
            check($sformatf("vec%0d_writes", v), 32'(we_cnt - w0), 32'(vecs[v].writes));
            check($sformatf("vec%0d_errs", v), 32'(err_cnt - e0), 32'(vecs[v].errs));
            check($sformatf("vec%0d_data", v), data_kb, exp_last);
            check($sformatf("vec%0d_pend", v), {31'h0, pending_valid}, 32'h0);
        end
        check("addr_const", addr_kb, 32'h000000F0);

        // Slot occupied: key waits, latest key wins, then posts on release.
        w0 = we_cnt;
        @(negedge clk); code_key = 32'h0000001C;
        send_byte(8'h32, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("busy_nowrite", 32'(we_cnt - w0), 32'h0);
        check("busy_pend", {31'h0, pending_valid}, 32'h1);
        send_byte(8'h33, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("busy_nowrite2", 32'(we_cnt - w0), 32'h0);
        code_key = 32'h0;
        #1;
        check("release_we", {31'h0, we_kb}, 32'h1);
        check("release_data", data_kb, 32'h00000033);
        @(negedge clk);
        check("release_pend", {31'h0, pending_valid}, 32'h0);
        check("release_we_off", {31'h0, we_kb}, 32'h0);
        check("release_hold", data_kb, 32'h00000033);
        check("release_count", 32'(we_cnt - w0), 32'h1);

        // Truncated frame: start + 5 bits, then silence past the timeout.
        w0 = we_cnt; e0 = err_cnt;
        send_bits(8'h1C, 1'b0, 6);
        repeat (TMO + 50) @(posedge clk);
        @(negedge clk);
        check("tmo_err", 32'(err_cnt - e0), 32'h1);
        check("tmo_nowrite", 32'(we_cnt - w0), 32'h0);
        send_byte(8'h1C, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("tmo_next_write", 32'(we_cnt - w0), 32'h1);
        check("tmo_next_data", data_kb, 32'h0000001C);
        check("tmo_next_err", 32'(err_cnt - e0), 32'h1);

        // Reset with a key pending and a frame half received.
        code_key = 32'h5;
        send_byte(8'h32, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre_rst_pend", {31'h0, pending_valid}, 32'h1);
        send_bits(8'h4B, 1'b0, 5);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_rst_we", {31'h0, we_kb}, 32'h0);
        check("mid_rst_err", {31'h0, frame_err}, 32'h0);
        check("mid_rst_pend", {31'h0, pending_valid}, 32'h0);
        check("mid_rst_data", data_kb, 32'h0);
        check("mid_rst_addr", addr_kb, 32'h000000F0);
        rst = 1'b0;
        code_key = 32'h0;
        repeat (4) @(posedge clk);
        w0 = we_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_rst_write", 32'(we_cnt - w0), 32'h1);
        check("post_rst_data", data_kb, 32'h0000001C);
        check("post_rst_err", 32'(err_cnt - e0), 32'h0);

        check("we_rules", 32'(viol), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/kb_mem_writer.md
KB_MEM_WRITER -- requirements
Module: kb_mem_writer

Interface
REQ-001 Parameter KEY_ADDR, default 32'h0000_00F0, byte address of the key slot in data memory (word 60).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, the number of clk cycles without a PS/2 falling edge that aborts a frame.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 code_key  input  32  current contents of the key slot read back from data memory; 0 means the CPU has consumed the slot.
REQ-008 we_kb  output  1  memory write strobe for the key slot.
REQ-009 addr_kb  output  32  write address, always KEY_ADDR.
REQ-010 data_kb  output  32  key word to be written.
REQ-011 frame_err  output  1  one-cycle pulse on a rejected or aborted frame.
REQ-012 pending_valid  output  1  high while a decoded key is waiting to be written.

Function
REQ-013 ps2_clk and ps2_data shall each pass through a 2-FF synchronizer; a falling edge is detected as synced-previous=1 and synced-current=0.
REQ-014 The receiver FSM shall have the states IDLE, RECV and CHECK.
REQ-015 IDLE: on a falling edge with synced data=0 (start bit), go to RECV with bit_cnt=0; a start bit of 1 is ignored and the FSM stays in IDLE.
REQ-016 RECV: each falling edge samples synced data; bits 0-7 are data (LSB first), bit 8 is parity, bit 9 is stop; after bit 9, go to CHECK.
REQ-017 CHECK (one cycle): the frame is valid iff the ones-count of data+parity is odd and stop=1; valid frames emit the byte to the decoder, invalid frames pulse frame_err; either way, go to IDLE.
REQ-018 In RECV, a counter of cycles since the last falling edge that reaches TIMEOUT_CYCLES shall abort to IDLE, discard the partial byte and pulse frame_err for one cycle.
REQ-019 Decoder byte E0 shall set the ext flag.
REQ-020 Decoder byte F0 shall set the brk flag.
REQ-021 Decoder byte 00 shall be ignored, leaving the flags unchanged.
REQ-022 Any other decoder byte with brk=1 is a release: it is discarded and both flags clear.
REQ-023 Any other decoder byte with brk=0 is a make: it loads the pending register with {16'h0000, ext?8'hE0:8'h00, byte}, sets pending_valid, and clears both flags.
REQ-024 A new make code arriving while pending_valid=1 shall overwrite the pending register (latest key wins).
REQ-025 When pending_valid=1 and code_key==0, we_kb shall be high for exactly one cycle with data_kb=pending, and pending_valid shall clear in that same cycle.
REQ-026 we_kb shall never assert while code_key!=0, and never on two consecutive cycles.
REQ-027 If a make code loads in the same cycle as a write, the write uses the old pending value and the new code becomes pending (pending_valid stays 1).
REQ-028 data_kb shall hold the last written word between writes.
REQ-029 addr_kb shall be constant KEY_ADDR.

Reset
REQ-030 While rst=1, the FSM goes to IDLE; bit_cnt, timeout counter, ext, brk, pending register, synchronizers (to 1) and data_kb are zero.
REQ-031 While rst=1, we_kb, frame_err and pending_valid are 0, and addr_kb=KEY_ADDR.
REQ-032 Reset asserted mid-frame or with a key pending shall discard all partial state; the first complete frame after release shall decode normally.

Verification
REQ-033 Frame 0x1C (parity 0, stop 1) with code_key=0 -> exactly one we_kb pulse, data_kb=32'h0000001C, addr_kb=32'h000000F0.
REQ-034 Frames F0, 1C with code_key=0 -> no we_kb; ext and brk are 0 afterwards.
REQ-035 Frames E0, 75 with code_key=0 -> one write, data_kb=32'h0000E075.
REQ-036 Frame 0x1C with parity 1 -> one-cycle frame_err, no write; the next good frame 0x32 -> write 32'h00000032.
REQ-037 code_key=32'h1C held, then send 0x32 -> no write and pending_valid=1; drop code_key to 0 -> we_kb within 1 cycle with data_kb=32'h32, then pending_valid=0.
REQ-038 Send start + 5 bits then idle TIMEOUT_CYCLES -> frame_err pulse and FSM in IDLE; separately, assert rst mid-frame -> all outputs at reset values, and the following frame 0x1C is written correctly.
